mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Parametrised sequential successor to the combinational DATAWIDTH multiplier.
- Radix-2 shift-add core that computes one operand bit per clock.
- Selectable signed or unsigned mode per transaction.
- Returns both the full 2*DATAWIDTH product and the truncated DATAWIDTH product, with an overflow flag.
- Valid/ready handshakes on input and output, so it can sit in datapaths where a full-width combinational multiplier misses timing or costs too many DSPs.

Parameters:
DATAWIDTH, 32, operand width and truncated-product width (>= 2)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous reset, active-low
a  input  DATAWIDTH  multiplicand
b  input  DATAWIDTH  multiplier
sgn  input  1  1 = two's-complement operands, 0 = unsigned
in_valid  input  1  a/b/sgn valid
in_ready  output  1  block can accept an operand pair
prod  output  DATAWIDTH  low DATAWIDTH bits of the product
prod_full  output  2*DATAWIDTH  full product
ovf  output  1  product not representable in DATAWIDTH bits
out_valid  output  1  prod/prod_full/ovf valid
out_ready  input  1  consumer accepts the result

Behaviour:
- Reset (Rst low at a Clk edge), in every state:
  - State goes to IDLE.
  - in_ready=1 in the following cycle.
  - out_valid=0, prod=0, prod_full=0, ovf=0.
  - Internal accumulator and counter are cleared.
  - An in-flight operation is discarded and no result is produced.
- State machine: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE); combinational from state only.
- IDLE:
  - Accept on an edge where in_valid && in_ready.
  - Latch sgn. If sgn=1, latch |a| and |b| and the result sign = a[MSB]^b[MSB]. If sgn=0, latch a and b unchanged.
  - Clear the accumulator; set the counter to DATAWIDTH; go to BUSY.
  - a/b/sgn changes after acceptance have no effect.
- BUSY, one edge per bit:
  - If the multiplier LSB is 1, add the multiplicand (zero-extended to 2*DATAWIDTH) to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Decrement the counter.
  - On the edge where the counter reaches 0, go to DONE.
- Entering DONE, on the final BUSY edge:
  - prod_full = the accumulator, negated (two's complement, 2*DATAWIDTH wide) when sgn=1 and the result sign is 1.
  - prod = prod_full[DATAWIDTH-1:0].
  - out_valid=1.
  - ovf:
    - sgn=0: 1 iff prod_full[2*DATAWIDTH-1:DATAWIDTH] != 0.
    - sgn=1: 1 iff prod_full[2*DATAWIDTH-1:DATAWIDTH-1] is not all-zeros and not all-ones.
- DONE:
  - Outputs hold stable while out_valid && !out_ready.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - prod/prod_full/ovf keep their last values after handoff; consumers sample only when out_valid=1.
  - No new input is accepted in DONE, even when out_ready=1 on the same edge.
- Latency:
  - Accept edge T gives out_valid=1 after edge T+DATAWIDTH.
  - Minimum initiation interval is DATAWIDTH+2 cycles when out_ready is held at 1.
- Boundary cases:
  - Signed minimum operand (e.g. -2^(DATAWIDTH-1)): |x| fits in DATAWIDTH unsigned bits; no special case.
  - Zero operand: still takes the full DATAWIDTH cycles; the result is 0 with ovf=0, and a negative zero must not appear.
  - in_valid asserted in BUSY or DONE is ignored (in_ready=0); the source must hold it.
  - out_ready asserted before out_valid has no effect.
  - Rst low concurrent with an accept or an output handshake: reset wins.

Test Plan (DATAWIDTH=8 unless stated):
- Reset and latency: hold Rst=0 for 3 cycles, then release; check in_ready=1, out_valid=0, prod=0. Accept a=15, b=17, sgn=0 at edge T → out_valid rises after edge T+8 with prod_full=0x00FF, prod=0xFF, ovf=0.
- Unsigned overflow: a=200, b=3, sgn=0 → prod_full=0x0258, prod=0x58, ovf=1.
- Signed results:
  - a=0xFD (-3), b=0x05, sgn=1 → prod_full=0xFFF1, prod=0xF1, ovf=0.
  - a=0x80, b=0x80, sgn=1 → prod_full=0x4000, prod=0x00, ovf=1.
  - a=0x80, b=0x01, sgn=1 → prod_full=0xFF80, ovf=0.
- Backpressure: complete a=7, b=9 with out_ready=0 for 5 cycles → out_valid stays 1 and prod=63 stays stable, in_ready=0; a new in_valid is not accepted. Raise out_ready → handoff; in_ready=1 the next cycle.
- Reset mid-operation: accept a=255, b=255, sgn=0; pull Rst low 4 cycles in → IDLE next cycle, no out_valid pulse. Then accept a=2, b=3 → prod=6 after 8 cycles.
- Back-to-back and width sweep: with out_ready=1, issue 100 random pairs per mode. Compare against a reference model, checking the DATAWIDTH+2 initiation interval. Repeat with DATAWIDTH=32, including 0xFFFFFFFF*0xFFFFFFFF unsigned → prod_full=0xFFFFFFFE00000001, ovf=1.

Source files
------------

// File: rtl/mul_seq.sv
// mul_seq -- sequential radix-2 shift-add multiplier.
//
// Purpose:
//   Multiplies two DATAWIDTH-bit operands, retiring one multiplier bit per
//   clock. Each transaction selects signed (two's-complement) or unsigned
//   operands. Both the full 2*DATAWIDTH product and its low DATAWIDTH bits are
//   returned, together with a flag that is set when the product does not fit
//   in DATAWIDTH bits. Input and output use valid/ready handshakes.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous reset, active-low
//   a, b       multiplicand / multiplier (DATAWIDTH bits)
//   sgn        1 = operands are two's complement, 0 = unsigned
//   in_valid   a/b/sgn are valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   prod       low DATAWIDTH bits of the product
//   prod_full  full 2*DATAWIDTH product
//   ovf        product not representable in DATAWIDTH bits
//   out_valid  prod/prod_full/ovf are valid (high only in DONE)
//   out_ready  consumer accepts the result
//
// Timing: accept on edge T, out_valid is high after edge T+DATAWIDTH.
// With out_ready held high the next accept can happen DATAWIDTH+2 edges
// after the previous one.

module mul_seq #(
  parameter int DATAWIDTH = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [DATAWIDTH-1:0]     a,
  input  logic [DATAWIDTH-1:0]     b,
  input  logic                     sgn,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATAWIDTH-1:0]     prod,
  output logic [2*DATAWIDTH-1:0]   prod_full,
  output logic                     ovf,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int PW = 2 * DATAWIDTH;
  localparam int CW = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         mcand_q, mcand_d;
  logic [DATAWIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sgn_q, sgn_d;
  logic                  neg_q, neg_d;
  logic [PW-1:0]         prod_full_q, prod_full_d;
  logic                  ovf_q, ovf_d;

  logic [DATAWIDTH-1:0]  absA;
  logic [DATAWIDTH-1:0]  absB;
  logic [PW-1:0]         accSum;
  logic [PW-1:0]         resultFull;
  logic [DATAWIDTH:0]    signedTop;
  logic                  resultOvf;

  // Magnitudes of the incoming operands. In signed mode a negative operand is
  // negated; the most negative value maps onto itself, which read as unsigned
  // is exactly its magnitude, so no special case is needed.
  always_comb begin
    absA = a;
    absB = b;
    if (sgn && a[DATAWIDTH-1]) begin
      absA = ~a + DATAWIDTH'(1);
    end
    if (sgn && b[DATAWIDTH-1]) begin
      absB = ~b + DATAWIDTH'(1);
    end
  end

  // One shift-add step plus the final sign fix-up and overflow test. The
  // result is formed from the accumulator value including the last step so
  // that it can be registered on the same edge that leaves BUSY.
  always_comb begin
    accSum = acc_q + (mplier_q[0] ? mcand_q : '0);
    resultFull = accSum;
    if (sgn_q && neg_q) begin
      resultFull = ~accSum + PW'(1);
    end
    // A signed result fits when the top DATAWIDTH+1 bits are a pure sign
    // extension; an unsigned result fits when the upper half is zero.
    signedTop = resultFull[PW-1:DATAWIDTH-1];
    if (sgn_q) begin
      resultOvf = !((&signedTop) || !(|signedTop));
    end else begin
      resultOvf = |resultFull[PW-1:DATAWIDTH];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    neg_d       = neg_q;
    prod_full_d = prod_full_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{DATAWIDTH{1'b0}}, absA};
          mplier_d = absB;
          acc_d    = '0;
          cnt_d    = CW'(DATAWIDTH);
          sgn_d    = sgn;
          neg_d    = sgn && (a[DATAWIDTH-1] ^ b[DATAWIDTH-1]);
          state_d  = BUSY;
        end
      end

      BUSY: begin
        acc_d    = accSum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_full_d = resultFull;
          ovf_d       = resultOvf;
          state_d     = DONE;
        end
      end

      DONE: begin
        // Input is never taken here, even when the result is handed off on
        // the same edge; the source sees in_ready only once back in IDLE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, discarding any
  // operation in flight, and takes priority over any handshake.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      prod_full_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      neg_q       <= neg_d;
      prod_full_q <= prod_full_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign prod_full = prod_full_q;
  assign prod      = prod_full_q[DATAWIDTH-1:0];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq -- self-checking bench for mul_seq.
//
// Purpose:
//   Drives an 8-bit and a 32-bit instance of mul_seq with directed and
//   random operand pairs and compares every result against plain integer
//   arithmetic. Also checks reset state, latency, initiation interval,
//   backpressure and reset during an operation.
//
// Ports: none (top-level bench).

module tb_mul_seq;

  logic        Clk = 1'b0;
  logic        Rst;

  logic [7:0]  a8, b8;
  logic        sgn8, inValid8, inReady8, ovf8, outValid8, outReady8;
  logic [7:0]  prod8;
  logic [15:0] prodFull8;

  logic [31:0] a32, b32;
  logic        sgn32, inValid32, inReady32, ovf32, outValid32, outReady32;
  logic [31:0] prod32;
  logic [63:0] prodFull32;

  int  vecCount  = 0;
  int  missCount = 0;
  time lastAccept8  = 0;
  time lastAccept32 = 0;

  always #5 Clk = ~Clk;

  mul_seq #(.DATAWIDTH(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .a(a8), .b(b8), .sgn(sgn8),
    .in_valid(inValid8), .in_ready(inReady8),
    .prod(prod8), .prod_full(prodFull8), .ovf(ovf8),
    .out_valid(outValid8), .out_ready(outReady8)
  );

  mul_seq #(.DATAWIDTH(32)) dut32 (
    .Clk(Clk), .Rst(Rst), .a(a32), .b(b32), .sgn(sgn32),
    .in_valid(inValid32), .in_ready(inReady32),
    .prod(prod32), .prod_full(prodFull32), .ovf(ovf32),
    .out_valid(outValid32), .out_ready(outReady32)
  );

  // Reference model: products by ordinary integer multiplication, overflow
  // by comparing the exact product against the representable range.
  function automatic logic [15:0] refFull8(input logic [7:0] av, input logic [7:0] bv,
                                           input logic sv);
    int p;
    if (sv) p = int'($signed(av)) * int'($signed(bv));
    else    p = int'(av) * int'(bv);
    return p[15:0];
  endfunction

  function automatic logic refOvf8(input logic [7:0] av, input logic [7:0] bv,
                                   input logic sv);
    int p;
    if (sv) begin
      p = int'($signed(av)) * int'($signed(bv));
      return (p < -128) || (p > 127);
    end
    p = int'(av) * int'(bv);
    return p > 255;
  endfunction

  function automatic logic [63:0] refFull32(input logic [31:0] av, input logic [31:0] bv,
                                            input logic sv);
    longint p;
    logic [63:0] u;
    if (sv) begin
      p = longint'($signed(av)) * longint'($signed(bv));
      return 64'(p);
    end
    u = {32'b0, av} * {32'b0, bv};
    return u;
  endfunction

  function automatic logic refOvf32(input logic [31:0] av, input logic [31:0] bv,
                                    input logic sv);
    longint p;
    logic [63:0] u;
    if (sv) begin
      p = longint'($signed(av)) * longint'($signed(bv));
      return (p < -64'sd2147483648) || (p > 64'sd2147483647);
    end
    u = {32'b0, av} * {32'b0, bv};
    return u > 64'h0000_0000_FFFF_FFFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full 8-bit transaction: accept, wait for the result, optionally stall
  // the consumer while poking in_valid, then hand off.
  task automatic applyStimulus8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                                input int stall, input bit checkIi);
    int guard;
    int lat;
    time acceptTime;
    logic [15:0] expFull;
    logic expOvf;
    expFull = refFull8(av, bv, sv);
    expOvf  = refOvf8(av, bv, sv);
    guard = 0;
    while (inReady8 !== 1'b1 && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("inReady8", {63'b0, inReady8}, 64'd1);
    a8 = av; b8 = bv; sgn8 = sv; inValid8 = 1'b1;
    outReady8 = (stall == 0);
    @(posedge Clk);
    acceptTime = $time;
    if (checkIi) checkOutput("initInterval8", (acceptTime - lastAccept8) / 10, 64'd10);
    lastAccept8 = acceptTime;
    #1;
    inValid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    lat = 0;
    do begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end while (outValid8 !== 1'b1 && lat < 40);
    checkOutput("latency8", 64'(lat), 64'd8);
    checkOutput("prodFull8", {48'b0, prodFull8}, {48'b0, expFull});
    checkOutput("prod8", {56'b0, prod8}, {56'b0, expFull[7:0]});
    checkOutput("ovf8", {63'b0, ovf8}, {63'b0, expOvf});
    for (int i = 0; i < stall; i++) begin
      inValid8 = 1'b1; a8 = 8'd1; b8 = 8'd1; sgn8 = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      checkOutput("stallValid8", {63'b0, outValid8}, 64'd1);
      checkOutput("stallProd8", {56'b0, prod8}, {56'b0, expFull[7:0]});
      checkOutput("stallReady8", {63'b0, inReady8}, 64'd0);
    end
    outReady8 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("handoffValid8", {63'b0, outValid8}, 64'd0);
    checkOutput("handoffReady8", {63'b0, inReady8}, 64'd1);
    checkOutput("holdProd8", {56'b0, prod8}, {56'b0, expFull[7:0]});
    inValid8 = 1'b0;
  endtask

  task automatic applyStimulus32(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                 input bit checkIi);
    int guard;
    int lat;
    time acceptTime;
    logic [63:0] expFull;
    logic expOvf;
    expFull = refFull32(av, bv, sv);
    expOvf  = refOvf32(av, bv, sv);
    guard = 0;
    while (inReady32 !== 1'b1 && guard < 80) begin
      @(negedge Clk);
      guard++;
    end
    checkOutput("inReady32", {63'b0, inReady32}, 64'd1);
    a32 = av; b32 = bv; sgn32 = sv; inValid32 = 1'b1; outReady32 = 1'b1;
    @(posedge Clk);
    acceptTime = $time;
    if (checkIi) checkOutput("initInterval32", (acceptTime - lastAccept32) / 10, 64'd34);
    lastAccept32 = acceptTime;
    #1;
    inValid32 = 1'b0;
    a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
    lat = 0;
    do begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end while (outValid32 !== 1'b1 && lat < 80);
    checkOutput("latency32", 64'(lat), 64'd32);
    checkOutput("prodFull32", prodFull32, expFull);
    checkOutput("prod32", {32'b0, prod32}, {32'b0, expFull[31:0]});
    checkOutput("ovf32", {63'b0, ovf32}, {63'b0, expOvf});
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("handoffValid32", {63'b0, outValid32}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected run to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawValid;
    Rst = 1'b0;
    a8 = '0; b8 = '0; sgn8 = 1'b0; inValid8 = 1'b0; outReady8 = 1'b1;
    a32 = '0; b32 = '0; sgn32 = 1'b0; inValid32 = 1'b0; outReady32 = 1'b1;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    checkOutput("rstInReady8", {63'b0, inReady8}, 64'd1);
    checkOutput("rstOutValid8", {63'b0, outValid8}, 64'd0);
    checkOutput("rstProd8", {56'b0, prod8}, 64'd0);
    checkOutput("rstProdFull8", {48'b0, prodFull8}, 64'd0);
    checkOutput("rstOvf8", {63'b0, ovf8}, 64'd0);
    checkOutput("rstInReady32", {63'b0, inReady32}, 64'd1);
    checkOutput("rstOutValid32", {63'b0, outValid32}, 64'd0);

    $display("[TB] directed 8-bit vectors");
    applyStimulus8(8'd15,  8'd17,  1'b0, 0, 1'b0);
    applyStimulus8(8'd200, 8'd3,   1'b0, 0, 1'b0);
    applyStimulus8(8'hFD,  8'h05,  1'b1, 0, 1'b0);
    applyStimulus8(8'h80,  8'h80,  1'b1, 0, 1'b0);
    applyStimulus8(8'h80,  8'h01,  1'b1, 0, 1'b0);
    applyStimulus8(8'h00,  8'hFF,  1'b1, 0, 1'b0);
    applyStimulus8(8'h80,  8'h00,  1'b1, 0, 1'b0);
    applyStimulus8(8'hFF,  8'hFF,  1'b1, 0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus8(8'd7, 8'd9, 1'b0, 5, 1'b0);

    $display("[TB] reset during an operation");
    @(negedge Clk);
    a8 = 8'd255; b8 = 8'd255; sgn8 = 1'b0; inValid8 = 1'b1;
    @(posedge Clk);
    #1;
    inValid8 = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    checkOutput("midRstInReady8", {63'b0, inReady8}, 64'd1);
    checkOutput("midRstOutValid8", {63'b0, outValid8}, 64'd0);
    checkOutput("midRstProdFull8", {48'b0, prodFull8}, 64'd0);
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge Clk);
      if (outValid8 === 1'b1) sawValid = 1'b1;
    end
    checkOutput("noGhostResult8", {63'b0, sawValid}, 64'd0);
    applyStimulus8(8'd2, 8'd3, 1'b0, 0, 1'b0);

    $display("[TB] random back-to-back 8-bit");
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 100; i++) begin
        applyStimulus8(8'($urandom), 8'($urandom), 1'(m), 0, i != 0);
      end
    end

    $display("[TB] 32-bit vectors");
    applyStimulus32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    applyStimulus32(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    applyStimulus32(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    applyStimulus32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus32($urandom, $urandom, 1'(m), 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
